// File: rtl/uart_pkg.sv
// Shared constants for the UART receive path: FIFO entry layout and level width.
package uart_pkg;
  localparam int BYTE_W   = 8;
  localparam int ENTRY_W  = 9;          // {perr, byte}
  localparam int BYTE_LSB = 0;
  localparam int BYTE_MSB = 7;
  localparam int PERR_BIT = 8;

  // Level counter must hold 0..depth inclusive.
  function automatic int level_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/uart_fifo_mem.sv
// Flop register file: one synchronous write port, one asynchronous read port.
module uart_fifo_mem #(
  parameter int DEPTH = 16,
  parameter int W     = 9,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [W-1:0]  i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [W-1:0]  o_rdata
);
  logic [W-1:0] r_mem [DEPTH];

  // Storage is intentionally unreset; the FIFO masks stale entries by count.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/uart_rx_fifo.sv
// Receive FIFO between the UART receiver and the register interface.
// Show-ahead head entry, level/full/almost-full flags, sticky overflow.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int AFULL_LEVEL = 12
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        fifo_write_n,
  input  logic [BYTE_W-1:0]           rx_byte,
  input  logic                        parity_err_in,
  input  logic                        read_rx_byte,
  input  logic                        clear_overflow,
  output logic [BYTE_W-1:0]           rx_data,
  output logic                        rx_data_perr,
  output logic                        rx_ready,
  output logic                        fifo_full,
  output logic                        almost_full,
  output logic [level_w(DEPTH)-1:0]   fifo_level,
  output logic                        overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = level_w(DEPTH);

  logic [AW-1:0]      r_wr_ptr, r_rd_ptr;
  logic [LW-1:0]      r_count;
  logic               r_overflow;

  logic               w_wr_req, w_full, w_empty;
  logic               w_pop, w_accept, w_drop;
  logic [ENTRY_W-1:0] w_wdata, w_rdata;

  assign w_wr_req = ~fifo_write_n;
  assign w_full   = (r_count == LW'(DEPTH));
  assign w_empty  = (r_count == '0);
  // A pop on an empty FIFO is ignored, so a same-cycle write into an empty FIFO
  // simply lands; a pop on a full FIFO frees the slot for the same-cycle write.
  assign w_pop    = read_rx_byte & ~w_empty;
  assign w_accept = w_wr_req & (~w_full | w_pop);
  assign w_drop   = w_wr_req & w_full & ~w_pop;

  assign w_wdata = {parity_err_in, rx_byte};

  uart_fifo_mem #(.DEPTH(DEPTH), .W(ENTRY_W), .AW(AW)) u_mem (
    .clk     (clk),
    .i_we    (w_accept),
    .i_waddr (r_wr_ptr),
    .i_wdata (w_wdata),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rdata)
  );

  // Pointers wrap naturally since DEPTH is a power of two; count tracks fill.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_accept) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)    r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_accept && !w_pop)      r_count <= r_count + LW'(1);
      else if (w_pop && !w_accept) r_count <= r_count - LW'(1);
    end
  end

  // Sticky overflow; a drop in the same cycle as a clear wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)               r_overflow <= 1'b0;
    else if (w_drop)         r_overflow <= 1'b1;
    else if (clear_overflow) r_overflow <= 1'b0;
  end

  // Outputs decode from registers only; head data is hidden while empty.
  assign rx_ready     = ~w_empty;
  assign rx_data      = w_empty ? '0   : w_rdata[BYTE_MSB:BYTE_LSB];
  assign rx_data_perr = w_empty ? 1'b0 : w_rdata[PERR_BIT];
  assign fifo_full    = w_full;
  assign almost_full  = (r_count >= LW'(AFULL_LEVEL));
  assign fifo_level   = r_count;
  assign overflow     = r_overflow;
endmodule
